// File: rtl/fuzzy_pkg.sv
// Shared types and widths for the interval type-2 fuzzy controller datapath.
// Centroid defaults and the Nie-Tan rule-weight helper live here.
package fuzzy_pkg;

  localparam int unsigned W_MF      = 8;
  localparam int unsigned W_PESO    = 9;
  localparam int unsigned W_DEN     = 11;
  localparam int unsigned W_NUM     = 19;
  localparam int unsigned DIV_ITERS = 19;
  localparam int unsigned W_CNT     = 5;

  localparam logic [W_MF-1:0] C1_DEFAULT  = 8'd40;
  localparam logic [W_MF-1:0] C2_DEFAULT  = 8'd128;
  localparam logic [W_MF-1:0] C3_DEFAULT  = 8'd220;
  localparam logic [W_MF-1:0] OUT_DEFAULT = 8'd128;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDiv,
    StFim
  } state_e;

  // Nie-Tan rule weight: upper plus lower firing strength.
  function automatic logic [W_PESO-1:0] peso(input logic [W_MF-1:0] up,
                                             input logic [W_MF-1:0] low);
    return {1'b0, up} + {1'b0, low};
  endfunction

endpackage

// File: rtl/divisor_serial.sv
// Serial restoring divider, one quotient bit per clock, MSB first.
// The load edge performs the first iteration; pronto flags the cycle before the last edge.
module divisor_serial
  import fuzzy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             carrega,
  input  logic [W_NUM-1:0] dividendo,
  input  logic [W_DEN-1:0] divisor,
  output logic             ocupado,
  output logic             pronto,
  output logic [W_MF-1:0]  quociente
);

  logic [W_DEN-1:0] rem_q, rem_d, src_rem;
  logic [W_NUM-1:0] dvd_q, dvd_d, src_dvd;
  logic [W_DEN-1:0] dsr_q, src_dsr;
  logic [W_MF-1:0]  quo_q, quo_d, src_quo;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [W_DEN:0]   trial;
  logic             ge;

  always_comb begin
    src_rem = carrega ? '0        : rem_q;
    src_dvd = carrega ? dividendo : dvd_q;
    src_dsr = carrega ? divisor   : dsr_q;
    src_quo = carrega ? '0        : quo_q;

    trial = {src_rem, src_dvd[W_NUM-1]};
    ge    = (trial >= {1'b0, src_dsr});
    rem_d = ge ? W_DEN'(trial - {1'b0, src_dsr}) : trial[W_DEN-1:0];
    dvd_d = {src_dvd[W_NUM-2:0], 1'b0};
    // Upper quotient bits are provably zero, so only the low byte is kept.
    quo_d = {src_quo[W_MF-2:0], ge};

    cnt_d  = carrega ? W_CNT'(1) : cnt_q + W_CNT'(1);
    busy_d = carrega | (busy_q & (cnt_q != W_CNT'(DIV_ITERS - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (carrega || busy_q) begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dsr_q  <= src_dsr;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign ocupado   = busy_q;
  assign pronto    = busy_q & (cnt_q == W_CNT'(DIV_ITERS - 1));
  assign quociente = quo_d;

endmodule

// File: rtl/defuzzificador.sv
// Nie-Tan type reduction plus centroid defuzzification for three rules.
// Serial accumulation of weights, then a serial division for the crisp output.
module defuzzificador
  import fuzzy_pkg::*;
#(
  parameter logic [W_MF-1:0] C1          = C1_DEFAULT,
  parameter logic [W_MF-1:0] C2          = C2_DEFAULT,
  parameter logic [W_MF-1:0] C3          = C3_DEFAULT,
  parameter logic [W_MF-1:0] DEFAULT_OUT = OUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inicio,
  input  logic [W_MF-1:0] F_UP_1,
  input  logic [W_MF-1:0] F_UP_2,
  input  logic [W_MF-1:0] F_UP_3,
  input  logic [W_MF-1:0] F_LOW_1,
  input  logic [W_MF-1:0] F_LOW_2,
  input  logic [W_MF-1:0] F_LOW_3,
  output logic            ocupado,
  output logic            pronto,
  output logic [W_MF-1:0] saida
);

  state_e           state_q, state_d;
  logic [W_MF-1:0]  up1_q, up2_q, up3_q, low1_q, low2_q, low3_q;
  logic [1:0]       idx_q, idx_d;
  logic [W_NUM-1:0] num_q, num_d, num_soma, produto;
  logic [W_DEN-1:0] den_q, den_d, den_soma;
  logic             pronto_q, pronto_d;
  logic [W_MF-1:0]  saida_q, saida_d;
  logic             captura;

  logic [W_MF-1:0]   up_sel, low_sel, c_sel;
  logic [W_PESO-1:0] w_atual;

  logic             div_carrega, div_ocupado, div_pronto;
  logic [W_MF-1:0]  div_quociente;

  always_comb begin
    unique case (idx_q)
      2'd0:    begin up_sel = up1_q; low_sel = low1_q; c_sel = C1; end
      2'd1:    begin up_sel = up2_q; low_sel = low2_q; c_sel = C2; end
      default: begin up_sel = up3_q; low_sel = low3_q; c_sel = C3; end
    endcase
    w_atual  = peso(up_sel, low_sel);
    produto  = W_NUM'(w_atual) * W_NUM'(c_sel);
    num_soma = num_q + produto;
    den_soma = den_q + W_DEN'(w_atual);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    den_d       = den_q;
    pronto_d    = 1'b0;
    saida_d     = saida_q;
    captura     = 1'b0;
    div_carrega = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inicio) begin
          captura = 1'b1;
          num_d   = '0;
          den_d   = '0;
          idx_d   = 2'd0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        num_d = num_soma;
        den_d = den_soma;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) begin
          state_d = (den_soma == '0) ? StFim : StDiv;
        end
      end
      StDiv: begin
        // Divider loads on the first DIV edge, then runs until its pronto.
        div_carrega = ~div_ocupado;
        if (div_pronto) begin
          saida_d  = div_quociente;
          pronto_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StFim: begin
        saida_d  = DEFAULT_OUT;
        pronto_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      num_q    <= '0;
      den_q    <= '0;
      pronto_q <= 1'b0;
      saida_q  <= '0;
      up1_q    <= '0;
      up2_q    <= '0;
      up3_q    <= '0;
      low1_q   <= '0;
      low2_q   <= '0;
      low3_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      den_q    <= den_d;
      pronto_q <= pronto_d;
      saida_q  <= saida_d;
      if (captura) begin
        up1_q  <= F_UP_1;
        up2_q  <= F_UP_2;
        up3_q  <= F_UP_3;
        low1_q <= F_LOW_1;
        low2_q <= F_LOW_2;
        low3_q <= F_LOW_3;
      end
    end
  end

  divisor_serial u_divisor (
    .clk       (clk),
    .rst       (rst),
    .carrega   (div_carrega),
    .dividendo (num_q),
    .divisor   (den_q),
    .ocupado   (div_ocupado),
    .pronto    (div_pronto),
    .quociente (div_quociente)
  );

  assign ocupado = (state_q != StIdle);
  assign pronto  = pronto_q;
  assign saida   = saida_q;

endmodule
